// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared types and WM8731 constants for the I2C codec responder
package codec_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACK_A   = 3'd2,
        ST_BYTE_HI = 3'd3,
        ST_ACK_HI  = 3'd4,
        ST_BYTE_LO = 3'd5,
        ST_ACK_LO  = 3'd6,
        ST_IGNORE  = 3'd7
    } i2c_rsp_state_e;

    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;
    localparam int         NUM_REGS        = 10;
    localparam logic [6:0] REG_RESET       = 7'd15;

    // Power-on values of R0..R9
    localparam logic [8:0] WM8731_DEFAULTS [NUM_REGS] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    // True when a register address lands in the implemented shadow file
    function automatic logic is_shadow_addr(input logic [6:0] addr);
        return addr < 7'(NUM_REGS);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_lvl,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizer chains; reset to the idle-high bus level so no edge fires on release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // History flops for edge detection on the synchronized levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    // SCL must be high in both samples so an SDA edge racing an SCL edge is not a condition
    assign o_sda_lvl  = sda_s;
    assign o_scl_rise = scl_s & ~scl_d;
    assign o_scl_fall = ~scl_s & scl_d;
    assign o_start    = scl_s & scl_d & sda_d & ~sda_s;
    assign o_stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - write-only I2C target modelling the WM8731 control port
module i2c_codec_responder
    import codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_reg_wr,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_bad_addr,
    output logic [7:0] o_wr_count
);

    logic           sda_lvl;
    logic           scl_rise;
    logic           scl_fall;
    logic           bus_start;
    logic           bus_stop;

    i2c_rsp_state_e state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_q;
    logic [7:0]     hi_q;
    logic           ack_held;
    logic [7:0]     shift_next;
    logic           in_byte;
    logic           in_ack;
    logic           commit;
    logic [6:0]     commit_addr;
    logic [8:0]     commit_data;
    logic [8:0]     shadow [NUM_REGS];

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda_lvl  (sda_lvl),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (bus_start),
        .o_stop     (bus_stop)
    );

    assign shift_next = {shift_q[6:0], sda_lvl};
    assign in_byte    = (state == ST_ADDR) || (state == ST_BYTE_HI) || (state == ST_BYTE_LO);
    assign in_ack     = (state == ST_ACK_A) || (state == ST_ACK_HI) || (state == ST_ACK_LO);

    // The frame commits on the SCL fall that starts driving the final ACK, unless a bus condition wins
    assign commit      = !bus_start && !bus_stop && (state == ST_ACK_LO) && scl_fall && !ack_held;
    assign commit_addr = hi_q[7:1];
    assign commit_data = {hi_q[0], shift_q};

    // Frame FSM: START/STOP override everything, bits shift on SCL rise, ACK drive moves on SCL fall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'd0;
            hi_q      <= 8'd0;
            ack_held  <= 1'b0;
            o_sda_oen <= 1'b0;
        end else if (bus_start) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            ack_held  <= 1'b0;
            o_sda_oen <= 1'b0;
        end else if (bus_stop) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            ack_held  <= 1'b0;
            o_sda_oen <= 1'b0;
        end else if (in_byte && scl_rise) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                ack_held <= 1'b0;
                if (state == ST_ADDR) begin
                    state <= (shift_next == {DEV_ADDR, 1'b0}) ? ST_ACK_A : ST_IGNORE;
                end else if (state == ST_BYTE_HI) begin
                    hi_q  <= shift_next;
                    state <= ST_ACK_HI;
                end else begin
                    state <= ST_ACK_LO;
                end
            end
        end else if (in_ack && scl_fall) begin
            if (!ack_held) begin
                o_sda_oen <= 1'b1;
                ack_held  <= 1'b1;
            end else begin
                o_sda_oen <= 1'b0;
                ack_held  <= 1'b0;
                bit_cnt   <= 3'd0;
                if (state == ST_ACK_A) begin
                    state <= ST_BYTE_HI;
                end else if (state == ST_ACK_HI) begin
                    state <= ST_BYTE_LO;
                end else begin
                    state <= ST_IGNORE;
                end
            end
        end
    end

    // Commit strobe and last-written address/data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_wr   <= 1'b0;
            o_reg_addr <= 7'd0;
            o_reg_data <= 9'd0;
        end else begin
            o_reg_wr <= commit;
            if (commit) begin
                o_reg_addr <= commit_addr;
                o_reg_data <= commit_data;
            end
        end
    end

    // Saturating commit counter and sticky unsupported-address flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_count <= 8'd0;
            o_bad_addr <= 1'b0;
        end else if (commit) begin
            if (o_wr_count != 8'hFF) begin
                o_wr_count <= o_wr_count + 8'd1;
            end
            if (!is_shadow_addr(commit_addr) && (commit_addr != REG_RESET)) begin
                o_bad_addr <= 1'b1;
            end
        end
    end

    // Shadow register file: direct writes to R0..R9, full reload on the reset register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= WM8731_DEFAULTS[i];
            end
        end else if (commit) begin
            if (commit_addr == REG_RESET) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    shadow[i] <= WM8731_DEFAULTS[i];
                end
            end else if (is_shadow_addr(commit_addr)) begin
                shadow[commit_addr[3:0]] <= commit_data;
            end
        end
    end

    // Combinational readback; unimplemented indices read as zero
    always_comb begin
        o_rd_data = 9'd0;
        if (i_rd_addr < 4'(NUM_REGS)) begin
            o_rd_data = shadow[i_rd_addr];
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - scoreboard bench for the I2C codec responder
module tb_i2c_codec_responder;

    localparam int Q = 2;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oen;
    logic       reg_wr;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       bad_addr;
    logic [7:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    logic        watch_drive = 1'b0;
    logic        saw_drive   = 1'b0;

    assign sda_bus = sda_m & ~sda_oen;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_oen  (sda_oen),
        .o_reg_wr   (reg_wr),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_bad_addr (bad_addr),
        .o_wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every commit strobe is matched against the oldest expected {addr,data}
    always @(negedge clk) begin
        if (rst_n && watch_drive && sda_oen) saw_drive = 1'b1;
        if (rst_n && reg_wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got addr 0x%0h data 0x%0h expected none", reg_addr, reg_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("commit_addr", {25'd0, reg_addr}, {25'd0, e[15:9]});
                check("commit_data", {23'd0, reg_data}, {23'd0, e[8:0]});
            end
        end
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7 - i]; wq(Q);
            scl   = 1'b1;     wq(Q);
            scl   = 1'b0;     wq(Q);
        end
    endtask

    task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic ack;
        send_bits(b, 8);
        sda_m = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        ack   = ~sda_bus;
        scl   = 1'b0; wq(Q);
        check(name, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    // Full frame; expected commit is queued before the bytes go out
    task automatic frame(input string name, input logic [7:0] a, input logic [7:0] h,
                         input logic [7:0] l, input logic [2:0] acks, input logic commits);
        if (commits) exp_q.push_back({h[7:1], h[0], l});
        i2c_start();
        send_byte({name, "_ack0"}, a, acks[2]);
        send_byte({name, "_ack1"}, h, acks[1]);
        send_byte({name, "_ack2"}, l, acks[0]);
        i2c_stop();
        wq(4);
    endtask

    task automatic check_reg(input string name, input logic [3:0] idx, input logic [8:0] exp);
        rd_addr = idx;
        #1;
        check(name, {23'd0, rd_data}, {23'd0, exp});
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] defs [10];
        logic [8:0] after5 [10];
        defs   = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        after5 = '{9'h17B, 9'h097, 9'h079, 9'h079, 9'h015, 9'h008, 9'h01F, 9'h00A, 9'h000, 9'h000};
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
        wq(4);
        check("rst_oen",   {31'd0, sda_oen},  32'd0);
        check("rst_wr",    {31'd0, reg_wr},   32'd0);
        check("rst_addr",  {25'd0, reg_addr}, 32'd0);
        check("rst_data",  {23'd0, reg_data}, 32'd0);
        check("rst_bad",   {31'd0, bad_addr}, 32'd0);
        check("rst_count", {24'd0, wr_count}, 32'd0);
        for (int i = 0; i < 10; i++) check_reg($sformatf("rst_R%0d", i), 4'(i), defs[i]);
        rst_n = 1'b1;
        wq(4);

        // 1: reset register, R0, R4
        frame("t1a", 8'h34, 8'h1E, 8'h00, 3'b111, 1'b1);
        frame("t1b", 8'h34, 8'h01, 8'h7B, 3'b111, 1'b1);
        frame("t1c", 8'h34, 8'h08, 8'h15, 3'b111, 1'b1);
        check_reg("t1_R0", 4'd0, 9'h17B);
        check_reg("t1_R4", 4'd4, 9'h015);
        check_reg("t1_R1", 4'd1, 9'h097);
        check("t1_count", {24'd0, wr_count}, 32'd3);
        check("t1_bad",   {31'd0, bad_addr}, 32'd0);

        // 2: wrong device address is never driven
        watch_drive = 1'b1; saw_drive = 1'b0;
        frame("t2", 8'h36, 8'h00, 8'h10, 3'b000, 1'b0);
        watch_drive = 1'b0;
        check("t2_no_drive", {31'd0, saw_drive}, 32'd0);
        check("t2_count", {24'd0, wr_count}, 32'd3);

        // 3: read request is ignored
        i2c_start();
        send_byte("t3_ack0", 8'h35, 1'b0);
        send_byte("t3_ack1", 8'h02, 1'b0);
        i2c_stop();
        wq(4);
        check("t3_count", {24'd0, wr_count}, 32'd3);

        // 4: STOP in the middle of the low byte aborts
        i2c_start();
        send_byte("t4_ack0", 8'h34, 1'b1);
        send_byte("t4_ack1", 8'h0C, 1'b1);
        send_bits(8'hA0, 4);
        i2c_stop();
        wq(4);
        check("t4_oen",   {31'd0, sda_oen},  32'd0);
        check("t4_count", {24'd0, wr_count}, 32'd3);
        frame("t4b", 8'h34, 8'h0C, 8'h1F, 3'b111, 1'b1);
        check_reg("t4_R6", 4'd6, 9'h01F);
        check("t4b_count", {24'd0, wr_count}, 32'd4);

        // 5: unsupported register 10 is acked but flagged
        frame("t5", 8'h34, 8'h14, 8'h01, 3'b111, 1'b1);
        check("t5_bad",   {31'd0, bad_addr}, 32'd1);
        check("t5_count", {24'd0, wr_count}, 32'd5);
        for (int i = 0; i < 10; i++) check_reg($sformatf("t5_R%0d", i), 4'(i), after5[i]);
        check_reg("t5_R12", 4'd12, 9'h000);

        // 5b: reset register with nonzero data still reloads defaults
        frame("t5b", 8'h34, 8'h1E, 8'hAB, 3'b111, 1'b1);
        check_reg("t5b_R0", 4'd0, 9'h097);
        check_reg("t5b_R6", 4'd6, 9'h09F);
        check("t5b_count", {24'd0, wr_count}, 32'd6);

        // 6: asynchronous reset while the high-byte ACK is being driven
        i2c_start();
        send_byte("t6_ack0", 8'h34, 1'b1);
        send_bits(8'h02, 8);
        wq(3);
        check("t6_oen_before", {31'd0, sda_oen}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_oen_async", {31'd0, sda_oen}, 32'd0);
        sda_m = 1'b1; scl = 1'b1;
        wq(4);
        rst_n = 1'b1;
        wq(4);
        check_reg("t6_R0", 4'd0, 9'h097);
        check("t6_count", {24'd0, wr_count}, 32'd0);
        check("t6_bad",   {31'd0, bad_addr}, 32'd0);
        frame("t6f", 8'h34, 8'h02, 8'h55, 3'b111, 1'b1);
        check_reg("t6_R1", 4'd1, 9'h055);
        check("t6f_count", {24'd0, wr_count}, 32'd1);

        // 256 commits in total since reset saturate the counter
        for (int i = 0; i < 255; i++) begin
            frame("sat", 8'h34, 8'h00, 8'(i), 3'b111, 1'b1);
            if (i == 253) check("sat_254", {24'd0, wr_count}, 32'd255);
        end
        check("sat_count", {24'd0, wr_count}, 32'd255);
        check_reg("sat_R0", 4'd0, 9'h0FE);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
